// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode/funct constants, ALU one-hot encoding,
// decode control bundle, decode-to-execute bus layout and hazard helper.
package cpu_pkg;

    // Primary opcodes (inst[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    // SPECIAL funct codes (inst[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    // ALU operation one-hot bit positions
    localparam int unsigned ALU_OP_WD = 12;
    localparam int unsigned ALU_ADD  = 0;
    localparam int unsigned ALU_SUB  = 1;
    localparam int unsigned ALU_SLT  = 2;
    localparam int unsigned ALU_SLTU = 3;
    localparam int unsigned ALU_AND  = 4;
    localparam int unsigned ALU_NOR  = 5;
    localparam int unsigned ALU_OR   = 6;
    localparam int unsigned ALU_XOR  = 7;
    localparam int unsigned ALU_SLL  = 8;
    localparam int unsigned ALU_SRL  = 9;
    localparam int unsigned ALU_SRA  = 10;
    localparam int unsigned ALU_LUI  = 11;   // result = src2 << 16

    localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

    typedef struct packed {
        logic [ALU_OP_WD-1:0] alu_op;
        logic use_rs;
        logic use_rt;
        logic src1_is_sa;
        logic src1_is_pc;
        logic src2_is_simm;
        logic src2_is_zimm;
        logic src2_is_8;
        logic dst_is_rt;
        logic dst_is_31;
        logic gr_we;
        logic load_op;
        logic mem_we;
        logic is_beq;
        logic is_bne;
        logic is_j;
        logic is_jr;
    } ctrl_t;

    // Decode-to-execute bus; st_data carries rt for stores.
    typedef struct packed {
        logic [ALU_OP_WD-1:0] alu_op;
        logic                 load_op;
        logic                 mem_we;
        logic [4:0]           dest;
        logic [31:0]          src1;
        logic [31:0]          src2;
        logic [31:0]          st_data;
        logic [31:0]          pc;
    } de_to_es_t;

    localparam int unsigned DE_TO_ES_BUS_WD = ALU_OP_WD + 2 + 5 + 4 * 32;

    // True when a used, nonzero source register is written by a valid stage.
    function automatic logic dest_match(input logic [4:0] src, input logic used,
                                        input logic valid, input logic [4:0] dest);
        return used && (src != 5'd0) && valid && (dest == src);
    endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Combinational opcode/funct decoder producing the decode control bundle.
// Ports:
//   inst - instruction word in the decode register
//   ctrl - decoded control signals; unknown encodings decode to all-zero (nop)
module decode_ctrl
    import cpu_pkg::*;
(
    input  logic [31:0] inst,
    output ctrl_t       ctrl
);

    logic [5:0] op;
    logic [5:0] funct;

    assign op    = inst[31:26];
    assign funct = inst[5:0];

    always_comb begin
        ctrl = '0;
        unique case (op)
            OP_SPECIAL: begin
                ctrl.use_rs = 1'b1;
                ctrl.use_rt = 1'b1;
                ctrl.gr_we  = 1'b1;
                unique case (funct)
                    FN_ADDU: ctrl.alu_op[ALU_ADD]  = 1'b1;
                    FN_SUBU: ctrl.alu_op[ALU_SUB]  = 1'b1;
                    FN_SLT:  ctrl.alu_op[ALU_SLT]  = 1'b1;
                    FN_SLTU: ctrl.alu_op[ALU_SLTU] = 1'b1;
                    FN_AND:  ctrl.alu_op[ALU_AND]  = 1'b1;
                    FN_OR:   ctrl.alu_op[ALU_OR]   = 1'b1;
                    FN_XOR:  ctrl.alu_op[ALU_XOR]  = 1'b1;
                    FN_NOR:  ctrl.alu_op[ALU_NOR]  = 1'b1;
                    FN_SLL, FN_SRL, FN_SRA: begin
                        ctrl.use_rs     = 1'b0;
                        ctrl.src1_is_sa = 1'b1;
                        ctrl.alu_op[ALU_SLL] = (funct == FN_SLL);
                        ctrl.alu_op[ALU_SRL] = (funct == FN_SRL);
                        ctrl.alu_op[ALU_SRA] = (funct == FN_SRA);
                    end
                    FN_JR: begin
                        ctrl.use_rt = 1'b0;
                        ctrl.gr_we  = 1'b0;
                        ctrl.is_jr  = 1'b1;
                    end
                    default: ctrl = '0;
                endcase
            end
            OP_ADDIU: begin
                ctrl.use_rs = 1'b1; ctrl.src2_is_simm = 1'b1;
                ctrl.dst_is_rt = 1'b1; ctrl.gr_we = 1'b1; ctrl.alu_op[ALU_ADD] = 1'b1;
            end
            OP_LUI: begin
                ctrl.src2_is_zimm = 1'b1; ctrl.dst_is_rt = 1'b1;
                ctrl.gr_we = 1'b1; ctrl.alu_op[ALU_LUI] = 1'b1;
            end
            OP_LW: begin
                ctrl.use_rs = 1'b1; ctrl.src2_is_simm = 1'b1; ctrl.dst_is_rt = 1'b1;
                ctrl.gr_we = 1'b1; ctrl.load_op = 1'b1; ctrl.alu_op[ALU_ADD] = 1'b1;
            end
            OP_SW: begin
                ctrl.use_rs = 1'b1; ctrl.use_rt = 1'b1; ctrl.src2_is_simm = 1'b1;
                ctrl.mem_we = 1'b1; ctrl.alu_op[ALU_ADD] = 1'b1;
            end
            OP_BEQ: begin
                ctrl.use_rs = 1'b1; ctrl.use_rt = 1'b1; ctrl.is_beq = 1'b1;
            end
            OP_BNE: begin
                ctrl.use_rs = 1'b1; ctrl.use_rt = 1'b1; ctrl.is_bne = 1'b1;
            end
            OP_J: ctrl.is_j = 1'b1;
            OP_JAL: begin
                // Link value pc+8 is computed by the ALU as pc + 8.
                ctrl.is_j = 1'b1; ctrl.gr_we = 1'b1; ctrl.dst_is_31 = 1'b1;
                ctrl.src1_is_pc = 1'b1; ctrl.src2_is_8 = 1'b1; ctrl.alu_op[ALU_ADD] = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Pipeline decode stage: holds one instruction from fetch, reads operands,
// detects RAW hazards, resolves branches/jumps and emits the execute bus.
// Ports:
//   clk, reset                - clock, asynchronous active-high reset
//   fe_valid/fe_pc/fe_inst    - instruction offered by fetch
//   de_allowin                - decode can accept from fetch this cycle
//   es_allowin                - execute can accept from decode
//   de_to_es_valid/_bus       - decoded instruction to execute
//   rf_raddr1/2, rf_rdata1/2  - register file read port (rs, rt)
//   {es,ms,ws}_{dest,valid}   - downstream destinations for hazard checks
//   es_is_load                - execute holds a load
//   {es,ms,ws}_fwd            - downstream results (bypass build only)
//   br_taken/br_target        - fetch redirect; delay slot is never squashed
//   de_block                  - decode stalled on a hazard
// Build option: define DE_BYPASS_EN to forward results and stall only on
// an execute-stage load-use; otherwise stall on any pending writer.
module decode_stage
    import cpu_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fe_valid,
    input  logic [31:0]                fe_pc,
    input  logic [31:0]                fe_inst,
    output logic                       de_allowin,
    input  logic                       es_allowin,
    output logic                       de_to_es_valid,
    output logic [DE_TO_ES_BUS_WD-1:0] de_to_es_bus,
    output logic [4:0]                 rf_raddr1,
    output logic [4:0]                 rf_raddr2,
    input  logic [31:0]                rf_rdata1,
    input  logic [31:0]                rf_rdata2,
    input  logic [4:0]                 es_dest,
    input  logic [4:0]                 ms_dest,
    input  logic [4:0]                 ws_dest,
    input  logic                       es_valid,
    input  logic                       ms_valid,
    input  logic                       ws_valid,
    input  logic                       es_is_load,
    input  logic [31:0]                es_fwd,
    input  logic [31:0]                ms_fwd,
    input  logic [31:0]                ws_fwd,
    output logic                       br_taken,
    output logic [31:0]                br_target,
    output logic                       de_block
);

    logic        de_valid_q;
    logic [31:0] de_pc_q;
    logic [31:0] de_inst_q;
    logic        de_ready_go;
    logic        hazard;
    ctrl_t       ctrl;
    de_to_es_t   bus;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm;
    logic [31:0] rs_value, rt_value, pc_plus4, simm;
    logic        br_cond;

    decode_ctrl u_decode_ctrl (
        .inst (de_inst_q),
        .ctrl (ctrl)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_valid_q <= 1'b0;
            de_pc_q    <= RESET_PC;
            de_inst_q  <= 32'h0;
        end else if (de_allowin) begin
            de_valid_q <= fe_valid;
            if (fe_valid) begin
                de_pc_q   <= fe_pc;
                de_inst_q <= fe_inst;
            end
        end
    end

    assign rs  = de_inst_q[25:21];
    assign rt  = de_inst_q[20:16];
    assign rd  = de_inst_q[15:11];
    assign sa  = de_inst_q[10:6];
    assign imm = de_inst_q[15:0];
    assign simm = {{16{imm[15]}}, imm};

    assign rf_raddr1 = rs;
    assign rf_raddr2 = rt;

`ifdef DE_BYPASS_EN
    // Youngest writer wins: es > ms > ws > regfile.
    always_comb begin
        rs_value = rf_rdata1;
        if (dest_match(rs, 1'b1, ws_valid, ws_dest)) rs_value = ws_fwd;
        if (dest_match(rs, 1'b1, ms_valid, ms_dest)) rs_value = ms_fwd;
        if (dest_match(rs, 1'b1, es_valid, es_dest)) rs_value = es_fwd;
        rt_value = rf_rdata2;
        if (dest_match(rt, 1'b1, ws_valid, ws_dest)) rt_value = ws_fwd;
        if (dest_match(rt, 1'b1, ms_valid, ms_dest)) rt_value = ms_fwd;
        if (dest_match(rt, 1'b1, es_valid, es_dest)) rt_value = es_fwd;
    end

    // Load data is not available until memory stage, so only that stalls.
    assign hazard = dest_match(rs, ctrl.use_rs, es_valid && es_is_load, es_dest)
                 || dest_match(rt, ctrl.use_rt, es_valid && es_is_load, es_dest);
`else
    logic unused_fwd;
    assign unused_fwd = ^{es_fwd, ms_fwd, ws_fwd, es_is_load};

    assign rs_value = rf_rdata1;
    assign rt_value = rf_rdata2;

    assign hazard = dest_match(rs, ctrl.use_rs, es_valid, es_dest)
                 || dest_match(rs, ctrl.use_rs, ms_valid, ms_dest)
                 || dest_match(rs, ctrl.use_rs, ws_valid, ws_dest)
                 || dest_match(rt, ctrl.use_rt, es_valid, es_dest)
                 || dest_match(rt, ctrl.use_rt, ms_valid, ms_dest)
                 || dest_match(rt, ctrl.use_rt, ws_valid, ws_dest);
`endif

    assign de_ready_go    = !hazard;
    assign de_allowin     = !de_valid_q || (de_ready_go && es_allowin);
    assign de_to_es_valid = de_valid_q && de_ready_go;
    assign de_block       = de_valid_q && !de_ready_go;

    // Branch resolution
    assign pc_plus4 = de_pc_q + 32'd4;

    always_comb begin
        br_cond = (ctrl.is_beq && (rs_value == rt_value))
               || (ctrl.is_bne && (rs_value != rt_value))
               || ctrl.is_j || ctrl.is_jr;
        if (ctrl.is_jr) begin
            br_target = rs_value;
        end else if (ctrl.is_j) begin
            br_target = {pc_plus4[31:28], de_inst_q[25:0], 2'b00};
        end else begin
            br_target = pc_plus4 + {simm[29:0], 2'b00};
        end
    end

    // Gated by ready_go so a stalled branch never redirects with stale operands.
    assign br_taken = de_valid_q && de_ready_go && br_cond;

    // Output bus
    always_comb begin
        bus         = '0;
        bus.alu_op  = ctrl.alu_op;
        bus.load_op = ctrl.load_op;
        bus.mem_we  = ctrl.mem_we;
        if (!ctrl.gr_we)         bus.dest = 5'd0;
        else if (ctrl.dst_is_31) bus.dest = 5'd31;
        else if (ctrl.dst_is_rt) bus.dest = rt;
        else                     bus.dest = rd;
        if (ctrl.src1_is_sa)      bus.src1 = {27'd0, sa};
        else if (ctrl.src1_is_pc) bus.src1 = de_pc_q;
        else                      bus.src1 = rs_value;
        if (ctrl.src2_is_simm)      bus.src2 = simm;
        else if (ctrl.src2_is_zimm) bus.src2 = {16'd0, imm};
        else if (ctrl.src2_is_8)    bus.src2 = 32'd8;
        else                        bus.src2 = rt_value;
        bus.st_data = rt_value;
        bus.pc      = de_pc_q;
    end

    assign de_to_es_bus = bus;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; expectations follow the
// DE_BYPASS_EN build option when it is defined.
module tb_decode_stage;
    import cpu_pkg::*;

    logic                       clk;
    logic                       reset;
    logic                       fe_valid;
    logic [31:0]                fe_pc;
    logic [31:0]                fe_inst;
    logic                       de_allowin;
    logic                       es_allowin;
    logic                       de_to_es_valid;
    logic [DE_TO_ES_BUS_WD-1:0] de_to_es_bus;
    logic [4:0]                 rf_raddr1, rf_raddr2;
    logic [31:0]                rf_rdata1, rf_rdata2;
    logic [4:0]                 es_dest, ms_dest, ws_dest;
    logic                       es_valid, ms_valid, ws_valid;
    logic                       es_is_load;
    logic [31:0]                es_fwd, ms_fwd, ws_fwd;
    logic                       br_taken;
    logic [31:0]                br_target;
    logic                       de_block;

    logic [31:0] regs [32];
    de_to_es_t   bus;
    int          errors = 0;
    int          checks = 0;

    decode_stage u_dut (
        .clk            (clk),
        .reset          (reset),
        .fe_valid       (fe_valid),
        .fe_pc          (fe_pc),
        .fe_inst        (fe_inst),
        .de_allowin     (de_allowin),
        .es_allowin     (es_allowin),
        .de_to_es_valid (de_to_es_valid),
        .de_to_es_bus   (de_to_es_bus),
        .rf_raddr1      (rf_raddr1),
        .rf_raddr2      (rf_raddr2),
        .rf_rdata1      (rf_rdata1),
        .rf_rdata2      (rf_rdata2),
        .es_dest        (es_dest),
        .ms_dest        (ms_dest),
        .ws_dest        (ws_dest),
        .es_valid       (es_valid),
        .ms_valid       (ms_valid),
        .ws_valid       (ws_valid),
        .es_is_load     (es_is_load),
        .es_fwd         (es_fwd),
        .ms_fwd         (ms_fwd),
        .ws_fwd         (ws_fwd),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .de_block       (de_block)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model
    always_comb begin
        rf_rdata1 = (rf_raddr1 == 5'd0) ? 32'h0 : regs[rf_raddr1];
        rf_rdata2 = (rf_raddr2 == 5'd0) ? 32'h0 : regs[rf_raddr2];
    end

    assign bus = de_to_es_bus;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single edge, then withdraw fetch.
    task automatic issue(input logic [31:0] pc, input logic [31:0] inst);
        fe_valid = 1'b1;
        fe_pc    = pc;
        fe_inst  = inst;
        tick();
        fe_valid = 1'b0;
        #1;
    endtask

    task automatic clear_ds();
        es_valid = 1'b0; ms_valid = 1'b0; ws_valid = 1'b0; es_is_load = 1'b0;
        es_dest = 5'd0; ms_dest = 5'd0; ws_dest = 5'd0;
        es_fwd = 32'h0; ms_fwd = 32'h0; ws_fwd = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        reset = 1'b1; fe_valid = 1'b0; fe_pc = 32'h0; fe_inst = 32'h0; es_allowin = 1'b1;
        clear_ds();
        repeat (2) tick();
        check("rst_valid", {31'd0, de_to_es_valid}, 32'd0);
        check("rst_br", {31'd0, br_taken}, 32'd0);
        check("rst_block", {31'd0, de_block}, 32'd0);
        check("rst_allowin", {31'd0, de_allowin}, 32'd1);

        // First instruction after reset: addiu $1,$0,5
        reset = 1'b0; fe_valid = 1'b1; fe_pc = 32'hbfc0_0000; fe_inst = 32'h2401_0005;
        #1;
        check("pre_edge_valid", {31'd0, de_to_es_valid}, 32'd0);
        tick();
        fe_valid = 1'b0; #1;
        check("first_valid", {31'd0, de_to_es_valid}, 32'd1);
        check("first_pc", bus.pc, 32'hbfc0_0000);
        check("first_dest", {27'd0, bus.dest}, 32'd1);
        check("first_src2", bus.src2, 32'd5);
        check("first_alu", {20'd0, bus.alu_op}, 32'h1 << ALU_ADD);

        // Reset mid-stream discards the held instruction immediately
        #2 reset = 1'b1; #1;
        check("mid_rst_valid", {31'd0, de_to_es_valid}, 32'd0);
        check("mid_rst_block", {31'd0, de_block}, 32'd0);
        fe_valid = 1'b1;
        tick();
        reset = 1'b0; #1;
        check("in_rst_no_capture", {31'd0, de_to_es_valid}, 32'd0);
        tick();
        fe_valid = 1'b0; #1;
        check("post_rst_valid", {31'd0, de_to_es_valid}, 32'd1);
        check("post_rst_pc", bus.pc, 32'hbfc0_0000);

        // RAW on $1: addu $2,$1,$1 behind addiu $1
        fe_valid = 1'b1; fe_pc = 32'hbfc0_0004; fe_inst = 32'h0021_1021;
        tick();
        fe_valid = 1'b0; es_valid = 1'b1; es_dest = 5'd1; es_fwd = 32'd5; #1;
`ifdef DE_BYPASS_EN
        check("raw_block", {31'd0, de_block}, 32'd0);
        check("raw_valid", {31'd0, de_to_es_valid}, 32'd1);
        check("raw_src1", bus.src1, 32'd5);
        check("raw_src2", bus.src2, 32'd5);
`else
        check("raw_block_es", {31'd0, de_block}, 32'd1);
        check("raw_valid_es", {31'd0, de_to_es_valid}, 32'd0);
        check("raw_allowin_es", {31'd0, de_allowin}, 32'd0);
        tick();
        clear_ds(); ms_valid = 1'b1; ms_dest = 5'd1; #1;
        check("raw_block_ms", {31'd0, de_block}, 32'd1);
        tick();
        clear_ds(); ws_valid = 1'b1; ws_dest = 5'd1; #1;
        check("raw_block_ws", {31'd0, de_block}, 32'd1);
        tick();
        clear_ds(); regs[1] = 32'd5; #1;
        check("raw_valid", {31'd0, de_to_es_valid}, 32'd1);
        check("raw_src1", bus.src1, 32'd5);
        check("raw_src2", bus.src2, 32'd5);
`endif
        check("raw_dest", {27'd0, bus.dest}, 32'd2);
        tick();
        clear_ds(); regs[1] = 32'd5; #1;
        check("raw_drained", {31'd0, de_to_es_valid}, 32'd0);

        // Load-use: lw $3,0($0) then addu $4,$3,$3
        issue(32'hbfc0_0020, 32'h8c03_0000);
        check("lw_dest", {27'd0, bus.dest}, 32'd3);
        check("lw_load", {31'd0, bus.load_op}, 32'd1);
        fe_valid = 1'b1; fe_pc = 32'hbfc0_0024; fe_inst = 32'h0063_2021;
        tick();
        fe_valid = 1'b0; es_valid = 1'b1; es_dest = 5'd3; es_is_load = 1'b1; es_fwd = 32'h20;
        #1;
        check("lu_block", {31'd0, de_block}, 32'd1);
        check("lu_valid", {31'd0, de_to_es_valid}, 32'd0);
        tick();
        clear_ds(); ms_valid = 1'b1; ms_dest = 5'd3; ms_fwd = 32'h77; #1;
`ifdef DE_BYPASS_EN
        check("lu_block_after1", {31'd0, de_block}, 32'd0);
`else
        check("lu_block_ms", {31'd0, de_block}, 32'd1);
        tick();
        clear_ds(); ws_valid = 1'b1; ws_dest = 5'd3; #1;
        check("lu_block_ws", {31'd0, de_block}, 32'd1);
        tick();
        clear_ds(); regs[3] = 32'h77; #1;
        check("lu_block_done", {31'd0, de_block}, 32'd0);
`endif
        check("lu_src1", bus.src1, 32'h77);
        check("lu_src2", bus.src2, 32'h77);
        tick();
        clear_ds(); regs[3] = 32'h77;

        // Stalled bne $1,$0,+2 must not redirect until the hazard clears
        es_valid = 1'b1; es_dest = 5'd1; es_is_load = 1'b1;
        issue(32'hbfc0_0030, 32'h1420_0002);
        check("sb_block", {31'd0, de_block}, 32'd1);
        check("sb_br_stalled", {31'd0, br_taken}, 32'd0);
        clear_ds(); #1;
        check("sb_br", {31'd0, br_taken}, 32'd1);
        check("sb_target", br_target, 32'hbfc0_003c);
        tick();

        // beq $0,$0,-1 with delay slot or $5,$0,$0
        issue(32'hbfc0_0010, 32'h1000_ffff);
        check("beq_br", {31'd0, br_taken}, 32'd1);
        check("beq_target", br_target, 32'hbfc0_0010);
        check("beq_valid", {31'd0, de_to_es_valid}, 32'd1);
        fe_valid = 1'b1; fe_pc = 32'hbfc0_0014; fe_inst = 32'h0000_2825;
        tick();
        fe_valid = 1'b0; #1;
        check("ds_valid", {31'd0, de_to_es_valid}, 32'd1);
        check("ds_pc", bus.pc, 32'hbfc0_0014);
        check("ds_dest", {27'd0, bus.dest}, 32'd5);
        check("ds_br", {31'd0, br_taken}, 32'd0);
        tick();

        // bne $0,$0 not taken
        issue(32'hbfc0_0040, 32'h1400_0003);
        check("bne_nt_br", {31'd0, br_taken}, 32'd0);
        check("bne_nt_valid", {31'd0, de_to_es_valid}, 32'd1);
        tick();

        // Back-pressure for 3 cycles with the next instruction waiting in fetch
        issue(32'hbfc0_0050, 32'h0021_1021);
        es_allowin = 1'b0; fe_valid = 1'b1; fe_pc = 32'hbfc0_0054; fe_inst = 32'h0000_2825;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("bp_allowin", {31'd0, de_allowin}, 32'd0);
            check("bp_pc", bus.pc, 32'hbfc0_0050);
            check("bp_src1", bus.src1, 32'd5);
            tick();
        end
        es_allowin = 1'b1; #1;
        check("bp_release_allowin", {31'd0, de_allowin}, 32'd1);
        tick();
        fe_valid = 1'b0; #1;
        check("bp_next_pc", bus.pc, 32'hbfc0_0054);
        check("bp_next_valid", {31'd0, de_to_es_valid}, 32'd1);
        tick();
        check("bp_no_dup", {31'd0, de_to_es_valid}, 32'd0);

        // Hazard and back-pressure together: hazard wins
        es_allowin = 1'b0; es_valid = 1'b1; es_dest = 5'd1; es_is_load = 1'b1;
        issue(32'hbfc0_0060, 32'h0021_1021);
        check("hb_valid", {31'd0, de_to_es_valid}, 32'd0);
        check("hb_block", {31'd0, de_block}, 32'd1);
        check("hb_allowin", {31'd0, de_allowin}, 32'd0);
        clear_ds(); es_allowin = 1'b1;
        tick();

        // Jumps
        issue(32'hbfc0_fffc, 32'h0bff_ffff);
        check("j_br", {31'd0, br_taken}, 32'd1);
        check("j_target", br_target, 32'hbfff_fffc);
        check("j_dest", {27'd0, bus.dest}, 32'd0);
        tick();
        issue(32'hbfc0_0100, 32'h0c00_0040);
        check("jal_target", br_target, 32'hb000_0100);
        check("jal_dest", {27'd0, bus.dest}, 32'd31);
        check("jal_link", bus.src1 + bus.src2, 32'hbfc0_0108);
        tick();
        regs[31] = 32'h1234_5678;
        issue(32'hbfc0_0200, 32'h03e0_0008);
        check("jr_br", {31'd0, br_taken}, 32'd1);
        check("jr_target", br_target, 32'h1234_5678);
        tick();

        // sw $2,4($1)
        regs[2] = 32'hcafe_0002;
        issue(32'hbfc0_0300, 32'hac22_0004);
        check("sw_we", {31'd0, bus.mem_we}, 32'd1);
        check("sw_dest", {27'd0, bus.dest}, 32'd0);
        check("sw_src1", bus.src1, 32'd5);
        check("sw_src2", bus.src2, 32'd4);
        check("sw_data", bus.st_data, 32'hcafe_0002);
        tick();

        // sll $5,$2,3
        issue(32'hbfc0_0304, 32'h0002_28c0);
        check("sll_alu", {20'd0, bus.alu_op}, 32'h1 << ALU_SLL);
        check("sll_src1", bus.src1, 32'd3);
        check("sll_src2", bus.src2, 32'hcafe_0002);
        check("sll_dest", {27'd0, bus.dest}, 32'd5);
        tick();

        // lui $6,0x1234
        issue(32'hbfc0_0308, 32'h3c06_1234);
        check("lui_alu", {20'd0, bus.alu_op}, 32'h1 << ALU_LUI);
        check("lui_src2", bus.src2, 32'h0000_1234);
        check("lui_dest", {27'd0, bus.dest}, 32'd6);
        tick();

        // Unknown opcode decodes as nop
        issue(32'hbfc0_030c, 32'hfc07_0000);
        check("nop_dest", {27'd0, bus.dest}, 32'd0);
        check("nop_we", {31'd0, bus.mem_we}, 32'd0);
        check("nop_load", {31'd0, bus.load_op}, 32'd0);
        check("nop_br", {31'd0, br_taken}, 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
